// File: rtl/seq_booth_multiplier.sv
// Radix-4 Booth sequential multiplier, signed/unsigned per operation, start/busy/done handshake.
// Optional early termination for short multipliers is built when BOOTH_EARLY_TERM_EN is defined.
module seq_booth_multiplier #(
   parameter int N = 32
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           start,
   input  logic           signed_mode,
   input  logic [N-1:0]   multiplicand,
   input  logic [N-1:0]   multiplier,
   output logic [2*N-1:0] product,
   output logic           busy,
   output logic           done
);

   localparam int K     = (N + 2) / 2;
   localparam int CW    = $clog2(K + 1);
   localparam int W     = N + 2;
   localparam int AW    = N + 4;
   localparam int PRODW = 2 * N;

   typedef enum logic {
      IDLE,
      RUN
   } state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [AW-1:0]    acc_q, acc_d;
   logic [W-1:0]     b_q, b_d;
   logic             prev_q, prev_d;
   logic [W-1:0]     a_q, a_d;
   logic [PRODW-1:0] product_q, product_d;
   logic             done_q, done_d;

   logic [AW-1:0]    a_ext;
   logic [AW-1:0]    addend;
   logic [AW-1:0]    acc_sum;
   logic [AW-1:0]    acc_shift;
   logic [W-1:0]     b_shift;
   logic             last_iter;
   logic             rest_same;

`ifdef BOOTH_EARLY_TERM_EN
   localparam int PW = 2 * N + 6;
   localparam int SW = $clog2(PW + 1);
   logic [W-1:0]     rem_mask;
   logic [SW-1:0]    shamt;
   logic [PRODW-1:0] early_product;
`endif

   // Booth digit datapath: recode {B[2i+1], B[2i], B[2i-1]}, add d*A, shift {acc, B} right by 2.
   always_comb begin
      a_ext = {{2{a_q[W-1]}}, a_q};
      unique case ({b_q[1:0], prev_q})
         3'b001, 3'b010: addend = a_ext;
         3'b011:         addend = a_ext << 1;
         3'b100:         addend = -(a_ext << 1);
         3'b101, 3'b110: addend = -a_ext;
         default:        addend = '0;
      endcase
      acc_sum   = acc_q + addend;
      acc_shift = {{2{acc_sum[AW-1]}}, acc_sum[AW-1:2]};
      b_shift   = {acc_sum[1:0], b_q[W-1:2]};
      last_iter = (cnt_q == CW'(K - 1));
   end

`ifdef BOOTH_EARLY_TERM_EN
   // Remaining multiplier bits sit in b_q[W-1-2i:0]; uniform with the overlap bit means all later digits are 0.
   always_comb begin
      rem_mask      = {W{1'b1}} >> {cnt_q, 1'b0};
      rest_same     = (((b_q ^ {W{prev_q}}) & rem_mask) == '0);
      shamt         = SW'(2 * (K - int'(cnt_q)));
      early_product = PRODW'($signed({acc_q, b_q}) >>> shamt);
   end
`else
   assign rest_same = 1'b0;
`endif

   always_comb begin
      // NOTE: every _d gets its hold value first, so no path through this block can infer a latch.
      state_d   = state_q;
      cnt_d     = cnt_q;
      acc_d     = acc_q;
      b_d       = b_q;
      prev_d    = prev_q;
      a_d       = a_q;
      product_d = product_q;
      done_d    = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               a_d     = signed_mode ? {{2{multiplicand[N-1]}}, multiplicand} : {2'b00, multiplicand};
               b_d     = signed_mode ? {{2{multiplier[N-1]}}, multiplier} : {2'b00, multiplier};
               acc_d   = '0;
               cnt_d   = '0;
               prev_d  = 1'b0;
               state_d = RUN;
            end
         end
         RUN: begin
`ifdef BOOTH_EARLY_TERM_EN
            if (rest_same) begin
               product_d = early_product;
               done_d    = 1'b1;
               state_d   = IDLE;
            end else begin
`else
            begin
`endif
               acc_d  = acc_shift;
               b_d    = b_shift;
               prev_d = b_q[1];
               cnt_d  = cnt_q + 1'b1;
               if (last_iter) begin
                  product_d = PRODW'({acc_shift, b_shift});
                  done_d    = 1'b1;
                  state_d   = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: operand and accumulator registers are reset too, so an aborted op leaves no stale datapath state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         acc_q     <= '0;
         b_q       <= '0;
         prev_q    <= 1'b0;
         a_q       <= '0;
         product_q <= '0;
         done_q    <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments make every flop sample the pre-edge values of the others.
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         acc_q     <= acc_d;
         b_q       <= b_d;
         prev_q    <= prev_d;
         a_q       <= a_d;
         product_q <= product_d;
         done_q    <= done_d;
      end
   end

   assign product = product_q;
   assign busy    = (state_q == RUN);
   assign done    = done_q;

endmodule

// File: tb/tb_seq_booth_multiplier.sv
// Self-checking bench for seq_booth_multiplier (N=32): directed table, handshake corner cases,
// and random operands against a plain-arithmetic reference model.
module tb_seq_booth_multiplier;

   localparam int N = 32;
   localparam int K = (N + 2) / 2;

   logic          clk;
   logic          rst_n;
   logic          start;
   logic          signed_mode;
   logic [N-1:0]  multiplicand;
   logic [N-1:0]  multiplier;
   logic [2*N-1:0] product;
   logic          busy;
   logic          done;

   int n_checks;
   int n_fail;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        sm;
      logic [63:0] exp_p;
   } vec_t;

   vec_t vecs[11];

   seq_booth_multiplier #(.N(N)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .signed_mode  (signed_mode),
      .multiplicand (multiplicand),
      .multiplier   (multiplier),
      .product      (product),
      .busy         (busy),
      .done         (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
      end
   endtask

   function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b, input logic sm);
      longint sa;
      longint sb;
      sa = sm ? longint'($signed(a)) : longint'({32'b0, a});
      sb = sm ? longint'($signed(b)) : longint'({32'b0, b});
      return 64'(sa * sb);
   endfunction

   // Cycles from the accepting edge to the done edge.
   function automatic int exp_latency(input logic [31:0] b, input logic sm);
`ifdef BOOTH_EARLY_TERM_EN
      logic [34:0] v;
      bit          same;
      v = {(sm ? {2{b[31]}} : 2'b00), b, 1'b0};
      for (int i = 0; i < K; i++) begin
         same = 1'b1;
         for (int j = 2 * i + 1; j <= 34; j++)
            if (v[j] != v[2*i]) same = 1'b0;
         if (same) return i + 1;
      end
      return K;
`else
      return (b === 32'hx) ? 0 : K;
`endif
   endfunction

   // Drives a request now, lets the next edge accept it, then scrambles the inputs.
   task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic sm);
      multiplicand = a;
      multiplier   = b;
      signed_mode  = sm;
      start        = 1'b1;
      @(posedge clk);
      #1;
      start        = 1'b0;
      multiplicand = $urandom;
      multiplier   = $urandom;
      signed_mode  = 1'($urandom_range(0, 1));
   endtask

   // Called 1 time unit after the accepting edge; returns edges counted until done is seen.
   task automatic wait_done(output int lat, output bit busy_ok);
      lat     = 0;
      busy_ok = 1'b1;
      while (!done && lat < K + 4) begin
         if (!busy) busy_ok = 1'b0;
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sm,
                         output logic [63:0] p, output int lat, output bit busy_ok);
      @(negedge clk);
      launch(a, b, sm);
      wait_done(lat, busy_ok);
      p = product;
   endtask

   logic [63:0] p;
   int          lat;
   bit          busy_ok;
   logic [31:0] ra;
   logic [31:0] rb;
   logic        rsm;
   int          done_seen;

   initial begin
      n_checks     = 0;
      n_fail       = 0;
      rst_n        = 1'b0;
      start        = 1'b0;
      signed_mode  = 1'b0;
      multiplicand = '0;
      multiplier   = '0;

      vecs[0]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001};
      vecs[1]  = '{32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 64'hC000_0000_8000_0000};
      vecs[2]  = '{32'hFFFF_FFFF, 32'h0000_0002, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE};
      vecs[3]  = '{32'hFFFF_FFFF, 32'h0000_0002, 1'b0, 64'h0000_0001_FFFF_FFFE};
      vecs[4]  = '{32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000};
      vecs[5]  = '{32'h0000_0003, 32'h0000_0005, 1'b0, 64'd15};
      vecs[6]  = '{32'h0000_1234, 32'h0000_0001, 1'b0, 64'h1234};
      vecs[7]  = '{32'h0000_0005, 32'hFFFF_FFFF, 1'b1, 64'hFFFF_FFFF_FFFF_FFFB};
      vecs[8]  = '{32'hDEAD_BEEF, 32'h0000_0000, 1'b1, 64'h0};
      vecs[9]  = '{32'h0000_0003, 32'h8000_0000, 1'b0, 64'h1_8000_0000};
      vecs[10] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 64'h4000_0000_0000_0000};

      repeat (3) @(negedge clk);
      check("reset_product", product, 64'h0);
      check("reset_busy", 64'(busy), 64'h0);
      check("reset_done", 64'(done), 64'h0);
      rst_n = 1'b1;

      // Directed table: result, latency, busy through the op, single-cycle done.
      foreach (vecs[i]) begin
         run_op(vecs[i].a, vecs[i].b, vecs[i].sm, p, lat, busy_ok);
         check($sformatf("vec%0d_product", i), p, vecs[i].exp_p);
         check($sformatf("vec%0d_latency", i), 64'(lat), 64'(exp_latency(vecs[i].b, vecs[i].sm)));
         check($sformatf("vec%0d_busy_during_op", i), 64'(busy_ok), 64'h1);
         check($sformatf("vec%0d_busy_low_at_done", i), 64'(busy), 64'h0);
         @(posedge clk);
         #1;
         check($sformatf("vec%0d_done_single_cycle", i), 64'(done), 64'h0);
         check($sformatf("vec%0d_product_held", i), product, vecs[i].exp_p);
      end

      // Start pulsed while busy with different operands must be ignored.
      @(negedge clk);
      launch(32'h0000_1234, 32'h0000_5678, 1'b0);
      repeat (2) @(negedge clk);
      multiplicand = 32'hFFFF_FFFF;
      multiplier   = 32'hFFFF_FFFF;
      signed_mode  = 1'b1;
      start        = 1'b1;
      @(negedge clk);
      start        = 1'b0;
      #1;
      wait_done(lat, busy_ok);
      check("busy_start_ignored", product, 64'h1234 * 64'h5678);
      check("busy_start_done_seen", 64'(done), 64'h1);
      @(posedge clk);
      #1;
      check("busy_start_no_second_op", 64'(busy), 64'h0);

      // Asynchronous reset in the fifth RUN cycle.
      @(negedge clk);
      launch(32'h0012_3456, 32'h7654_3210, 1'b0);
      repeat (4) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("midrst_busy", 64'(busy), 64'h0);
      check("midrst_done", 64'(done), 64'h0);
      check("midrst_product", product, 64'h0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      done_seen = 0;
      repeat (K + 2) begin
         @(posedge clk);
         #1;
         if (done) done_seen++;
      end
      check("midrst_no_done", 64'(done_seen), 64'h0);
      run_op(32'd3, 32'd5, 1'b0, p, lat, busy_ok);
      check("after_reset_3x5", p, 64'd15);

      // Back-to-back: start held in the done cycle.
      run_op(32'h0001_0001, 32'h0000_FFFF, 1'b0, p, lat, busy_ok);
      check("b2b_first", p, 64'h0001_0001 * 64'h0000_FFFF);
      check("b2b_first_done", 64'(done), 64'h1);
      launch(32'd7, 32'd6, 1'b0);
      wait_done(lat, busy_ok);
      check("b2b_product", product, 64'd42);
      check("b2b_latency", 64'(lat), 64'(exp_latency(32'd6, 1'b0)));

      // Random operands; every fourth multiplier is small-magnitude to exercise short ops.
      for (int i = 0; i < 500; i++) begin
         ra  = $urandom;
         rb  = $urandom;
         rsm = 1'($urandom_range(0, 1));
         if (i % 4 == 0) begin
            rb = 32'($urandom_range(0, 255));
            if ($urandom_range(0, 1) == 1) rb = ~rb;
         end
         run_op(ra, rb, rsm, p, lat, busy_ok);
         check($sformatf("rand%0d_product a=%0h b=%0h s=%0d", i, ra, rb, rsm), p, ref_mul(ra, rb, rsm));
         check($sformatf("rand%0d_latency", i), 64'(lat), 64'(exp_latency(rb, rsm)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
